// File: rtl/n_alloc_pkg.sv
// Shared types for the circular slot allocator: error cause encoding and its classifier.
package n_alloc_pkg;

  typedef enum logic [1:0] {
    ERR_NONE        = 2'd0,
    ERR_DBL_FREE    = 2'd1,
    ERR_FREE_STAGED = 2'd2
  } err_cause_t;

  // A release of an already-clear slot outranks the staged-ID case.
  function automatic err_cause_t err_classify(input logic slot_clear, input logic slot_staged);
    err_cause_t c;
    c = ERR_NONE;
    if (slot_clear) begin
      c = ERR_DBL_FREE;
    end else if (slot_staged) begin
      c = ERR_FREE_STAGED;
    end
    return c;
  endfunction

endpackage

// File: rtl/n.sv
// Circular left-most-zero finder: first clear bit scanning pos-1, pos-2, ..., 0, W-1, ..., pos.
// Purely combinational; any_o is low only when every bit is set.
module n #(
  parameter int W   = 32,
  parameter int IDW = $clog2(W)
) (
  input  logic [W-1:0]   x_i,
  input  logic [IDW-1:0] pos_i,
  output logic [IDW-1:0] y_enc_o,
  output logic           any_o
);

  int             idx;
  logic [IDW-1:0] idx_t;

  always_comb begin
    y_enc_o = '0;
    any_o   = 1'b0;
    idx     = 0;
    idx_t   = '0;
    for (int k = 1; k <= W; k++) begin
      idx = int'(pos_i) - k;
      if (idx < 0) begin
        idx = idx + W;
      end
      idx_t = IDW'(idx);
      if (!any_o && !x_i[idx_t]) begin
        any_o   = 1'b1;
        y_enc_o = idx_t;
      end
    end
  end

endmodule

// File: rtl/n_alloc.sv
// Round-robin free-slot allocator: one staged ID per cycle, held stable under backpressure; frees searchable next cycle.
// Illegal-free detection (double free / free of staged ID) is compiled in with N_ALLOC_ERR_CHK_EN.
module n_alloc
  import n_alloc_pkg::*;
#(
  parameter  int W   = 32,
  localparam int IDW = $clog2(W)
) (
  input  logic           clk,
  input  logic           arst,
  output logic           alloc_vld_o,
  output logic [IDW-1:0] alloc_id_o,
  input  logic           alloc_rdy_i,
  input  logic           free_vld_i,
  input  logic [IDW-1:0] free_id_i,
  output logic [IDW:0]   cnt_o,
  output logic           full_o,
  output logic           err_o,
  output err_cause_t     err_cause_o
);

  localparam logic [IDW:0] CNT_FULL = (IDW+1)'(W);

  logic [W-1:0]   occ;
  logic [W-1:0]   occ_nxt;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] stg_id;
  logic           stg_vld;
  logic [IDW:0]   cnt;
  logic [IDW:0]   cnt_nxt;
  logic           full;
  logic [IDW-1:0] sel;
  logic           hit;
  logic           load;
  logic           hs;
  logic           free_in_rng;
  logic           free_ok;

  n #(.W(W)) u_find (
    .x_i     (occ),
    .pos_i   (ptr),
    .y_enc_o (sel),
    .any_o   (hit)
  );

  assign load        = hit & (~stg_vld | alloc_rdy_i);
  assign hs          = stg_vld & alloc_rdy_i;
  assign free_in_rng = int'(free_id_i) < W;

`ifdef N_ALLOC_ERR_CHK_EN
  logic       err;
  err_cause_t err_cause;
  err_cause_t free_cause;

  // Out-of-range IDs can never be owned, so they classify as a double free.
  always_comb begin
    free_cause = ERR_NONE;
    if (free_vld_i) begin
      free_cause = err_classify(~free_in_rng || !occ[free_id_i],
                                stg_vld && (stg_id == free_id_i));
    end
  end

  assign free_ok = free_vld_i & (free_cause == ERR_NONE);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      err       <= 1'b0;
      err_cause <= ERR_NONE;
    end else if (free_cause != ERR_NONE) begin
      err <= 1'b1;
      if (!err) begin
        err_cause <= free_cause;
      end
    end
  end

  assign err_o       = err;
  assign err_cause_o = err_cause;
`else
  assign free_ok     = free_vld_i & free_in_rng;
  assign err_o       = 1'b0;
  assign err_cause_o = ERR_NONE;
`endif

  // The search slot is always clear in occ, so set-after-clear order only matters for illegal frees.
  always_comb begin
    occ_nxt = occ;
    if (free_ok) begin
      occ_nxt[free_id_i] = 1'b0;
    end
    if (load) begin
      occ_nxt[sel] = 1'b1;
    end
    cnt_nxt = cnt + {{IDW{1'b0}}, load} - {{IDW{1'b0}}, free_ok};
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      occ     <= '0;
      ptr     <= '0;
      stg_vld <= 1'b0;
      stg_id  <= '0;
      cnt     <= '0;
      full    <= 1'b0;
    end else begin
      occ  <= occ_nxt;
      cnt  <= cnt_nxt;
      full <= (cnt_nxt == CNT_FULL);
      if (load) begin
        stg_vld <= 1'b1;
        stg_id  <= sel;
        ptr     <= sel;
      end else if (hs) begin
        stg_vld <= 1'b0;
      end
    end
  end

  assign alloc_vld_o = stg_vld;
  assign alloc_id_o  = stg_id;
  assign cnt_o       = cnt;
  assign full_o      = full;

endmodule

// File: tb/tb_n_alloc.sv
// Directed and randomized checks of n_alloc (W=16) against a set-based reference model.
module tb_n_alloc;
  import n_alloc_pkg::*;

  localparam int W   = 16;
  localparam int IDW = 4;

  logic           clk = 1'b0;
  logic           arst = 1'b1;
  logic           rdy = 1'b0;
  logic           fv = 1'b0;
  logic [IDW-1:0] fid = '0;
  logic           alloc_vld_o;
  logic [IDW-1:0] alloc_id_o;
  logic [IDW:0]   cnt_o;
  logic           full_o;
  logic           err_o;
  err_cause_t     err_cause_o;

  n_alloc #(.W(W)) dut (
    .clk         (clk),
    .arst        (arst),
    .alloc_vld_o (alloc_vld_o),
    .alloc_id_o  (alloc_id_o),
    .alloc_rdy_i (rdy),
    .free_vld_i  (fv),
    .free_id_i   (fid),
    .cnt_o       (cnt_o),
    .full_o      (full_o),
    .err_o       (err_o),
    .err_cause_o (err_cause_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;

  // Reference model: which IDs are taken, what is on offer, last grant, IDs held by the consumer.
  bit used[W];
  bit m_vld;
  int m_id;
  int m_ptr;
  bit m_err;
  int m_cause;
  int q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int used_cnt();
    int s = 0;
    for (int i = 0; i < W; i++) s += used[i];
    return s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < W; i++) used[i] = 0;
    m_vld = 0; m_id = 0; m_ptr = 0; m_err = 0; m_cause = 0;
    q.delete();
  endtask

  task automatic model_edge(input bit r, input bit f, input int id);
    int  sel;
    bit  load;
    bit  hs;
    bit  legal;
    int  dup;
    sel = -1;
    for (int k = 1; k <= W; k++) begin
      if (!used[(m_ptr - k + W) % W]) begin
        sel = (m_ptr - k + W) % W;
        break;
      end
    end
    load = (sel >= 0) && (!m_vld || r);
    hs   = m_vld && r;
    if (hs) begin
      dup = 0;
      foreach (q[i]) if (q[i] == m_id) dup = 1;
      chk("grant_unique", 32'(dup), 32'd0);
      q.push_back(m_id);
    end
    legal = 1;
`ifdef N_ALLOC_ERR_CHK_EN
    if (f) begin
      int c;
      c = 0;
      if (!used[id]) c = 1;
      else if (m_vld && m_id == id) c = 2;
      if (c != 0) begin
        legal = 0;
        if (!m_err) m_cause = c;
        m_err = 1;
      end
    end
`endif
    if (f && legal) begin
      used[id] = 0;
      for (int i = q.size() - 1; i >= 0; i--) if (q[i] == id) q.delete(i);
    end
    if (load) begin
      used[sel] = 1; m_vld = 1; m_id = sel; m_ptr = sel;
    end else if (hs) begin
      m_vld = 0;
    end
  endtask

  task automatic check_all();
    chk("vld", 32'(alloc_vld_o), 32'(m_vld));
    chk("id", 32'(alloc_id_o), 32'(m_id));
    chk("cnt", 32'(cnt_o), 32'(used_cnt()));
    chk("full", 32'(full_o), 32'(used_cnt() == W));
    chk("err", 32'(err_o), 32'(m_err));
    chk("err_cause", 32'(err_cause_o), 32'(m_cause));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(rdy, fv, int'(fid));
    #1;
    check_all();
  endtask

  task automatic do_reset();
    arst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    arst = 1'b0;
  endtask

  initial begin
    // Reset then drain with ready held high
    #2;
    do_reset();
    rdy = 1'b1;
    for (int i = 0; i < W; i++) begin
      step();
      chk("drain_id", 32'(alloc_id_o), 32'(15 - i));
    end
    chk("drain_cnt", 32'(cnt_o), 32'd16);
    chk("drain_full", 32'(full_o), 32'd1);
    step();
    chk("drain_vld_low", 32'(alloc_vld_o), 32'd0);

    // Wrap-around: ptr sits at 0, free 3 then 14
    fv = 1'b1; fid = 4'd3;
    step();
    chk("wrap_cnt", 32'(cnt_o), 32'd15);
    fid = 4'd14;
    step();
    chk("wrap_id3", 32'(alloc_id_o), 32'd3);
    fv = 1'b0;
    step();
    chk("wrap_id14", 32'(alloc_id_o), 32'd14);
    step();
    chk("wrap_vld_low", 32'(alloc_vld_o), 32'd0);

    // Refill from full with ID 9
    fv = 1'b1; fid = 4'd9;
    step();
    chk("refill_cnt15", 32'(cnt_o), 32'd15);
    fv = 1'b0;
    step();
    chk("refill_vld", 32'(alloc_vld_o), 32'd1);
    chk("refill_id", 32'(alloc_id_o), 32'd9);
    chk("refill_cnt16", 32'(cnt_o), 32'd16);
    step();

    // Mid-operation reset, then stall hold
    rdy = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_id", 32'(alloc_id_o), 32'd15);
      chk("stall_cnt", 32'(cnt_o), 32'd1);
    end
    rdy = 1'b1;
    step();
    chk("stall_next", 32'(alloc_id_o), 32'd14);
    step();

    // Grant 13 / stage 12 on the same edge as freeing 15
    fv = 1'b1; fid = 4'd15;
    step();
    chk("simul_cnt", 32'(cnt_o), 32'd3);
    chk("simul_id", 32'(alloc_id_o), 32'd12);
    fv = 1'b0;

`ifdef N_ALLOC_ERR_CHK_EN
    rdy = 1'b0;
    do_reset();
    fv = 1'b1; fid = 4'd5;
    step();
    chk("err_dbl", 32'(err_o), 32'd1);
    chk("err_dbl_cause", 32'(err_cause_o), 32'(ERR_DBL_FREE));
    fid = 4'd15;
    step();
    chk("err_keep_cause", 32'(err_cause_o), 32'(ERR_DBL_FREE));
    chk("err_staged_cnt", 32'(cnt_o), 32'd1);
    fv = 1'b0;
`endif

    // Randomized traffic with legal frees drawn from consumer-held IDs
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rdy = ($urandom_range(0, 3) != 0);
      fv  = 1'b0;
      if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
        fv  = 1'b1;
        fid = IDW'(q[$urandom_range(0, q.size() - 1)]);
      end
      if (c == 200) begin
        fv = 1'b0;
        do_reset();
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
